// File: rtl/trap_ctrl.sv
// trap_ctrl: trap-entry / mret sequencer that borrows the shared CSR write port.
// Ports:
//   clk, rst (async, active-low)
//   exc_addr, exc_ill, exc_ecall, irq_timer, mtie, mret : trap / return requests
//   freeze                                             : pipeline freeze, holds the sequencer
//   pc_id_ex, badaddr_val                              : values captured on trap entry
//   csr_mtvec, csr_mepc                                : redirect sources
//   core_wr_en, core_adr, core_data -> core_wr_ack     : core CSR write request
//   csr_wr_en, csr_adr_wr, csr_wrdata                  : shared CSR write port
//   trap_busy, flush, pc_redirect_en, pc_redirect, trap_en : pipeline control
module trap_ctrl #(
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000,
  parameter bit          TVAL_EN   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_addr,
  input  logic        exc_ill,
  input  logic        exc_ecall,
  input  logic        irq_timer,
  input  logic        mtie,
  input  logic        mret,
  input  logic        freeze,
  input  logic [31:0] pc_id_ex,
  input  logic [31:0] badaddr_val,
  input  logic [31:0] csr_mtvec,
  input  logic [31:0] csr_mepc,
  input  logic        core_wr_en,
  input  logic [11:0] core_adr,
  input  logic [31:0] core_data,
  output logic        csr_wr_en,
  output logic [11:0] csr_adr_wr,
  output logic [31:0] csr_wrdata,
  output logic        core_wr_ack,
  output logic        trap_busy,
  output logic        flush,
  output logic        pc_redirect_en,
  output logic [31:0] pc_redirect,
  output logic        trap_en
);
  typedef enum logic [2:0] {IDLE, SAVE_EPC, SAVE_CAUSE, SAVE_TVAL, REDIRECT, RET} state_t;
  state_t state, state_nxt;
  logic [31:0] cause, epc, tval, last_tgt, cause_nxt, mtvec_al;
  logic trap_req, idle, go, save;
  assign trap_req  = exc_addr | exc_ill | exc_ecall | (irq_timer & mtie);
  assign cause_nxt = exc_addr ? 32'h0 : exc_ill ? 32'h2 : exc_ecall ? 32'hB : 32'h8000_0007;
  assign idle      = state == IDLE;
  assign go        = !freeze;
  assign save      = state inside {SAVE_EPC, SAVE_CAUSE, SAVE_TVAL};
  assign mtvec_al  = csr_mtvec & ~32'h3;
  always_comb begin
    state_nxt = state;
    if (go)
      state_nxt = idle ? (trap_req ? SAVE_EPC : mret ? RET : IDLE) :
                  state == SAVE_EPC   ? SAVE_CAUSE :
                  state == SAVE_CAUSE ? ((TVAL_EN && cause == 32'h0) ? SAVE_TVAL : REDIRECT) :
                  state == SAVE_TVAL  ? REDIRECT : IDLE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cause    <= '0;
      epc      <= '0;
      tval     <= '0;
      last_tgt <= MTVEC_RST;
    end else begin
      state <= state_nxt;
      if (idle && go && trap_req) begin
        cause <= cause_nxt;
        epc   <= pc_id_ex;
        tval  <= badaddr_val;
      end
      if (pc_redirect_en) last_tgt <= pc_redirect;
    end
  end
  // In IDLE the core owns the CSR port; otherwise the sequencer does, gated by freeze.
  always_comb begin
    csr_wr_en      = idle ? core_wr_en : save & go;
    csr_adr_wr     = idle ? core_adr :
                     state == SAVE_EPC   ? 12'h341 :
                     state == SAVE_CAUSE ? 12'h342 :
                     state == SAVE_TVAL  ? 12'h343 : 12'h000;
    csr_wrdata     = idle ? core_data :
                     state == SAVE_EPC   ? epc :
                     state == SAVE_CAUSE ? cause :
                     state == SAVE_TVAL  ? tval : 32'h0;
    core_wr_ack    = idle & core_wr_en;
    trap_busy      = !idle;
    flush          = (state == SAVE_EPC) & go;
    trap_en        = (state == SAVE_EPC) & go;
    pc_redirect_en = (state == REDIRECT || state == RET) & go;
    pc_redirect    = state == REDIRECT ? mtvec_al : state == RET ? csr_mepc : last_tgt;
  end
endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed + random check of trap_ctrl against an action-list model.
module tb_trap_ctrl;
  localparam logic [31:0] MTVEC_RST = 32'hA5A0_0000;
  logic clk, rst, exc_addr, exc_ill, exc_ecall, irq_timer, mtie, mret, freeze, core_wr_en;
  logic [31:0] pc_id_ex, badaddr_val, csr_mtvec, csr_mepc, core_data;
  logic [11:0] core_adr;
  logic csr_wr_en, core_wr_ack, trap_busy, flush, pc_redirect_en, trap_en;
  logic [11:0] csr_adr_wr;
  logic [31:0] csr_wrdata, pc_redirect;
  typedef struct {logic wr; logic [11:0] adr; logic [31:0] data; logic fl; logic rd; logic ret;} act_t;
  act_t q[$];
  int checks = 0, errors = 0;
  trap_ctrl #(.MTVEC_RST(MTVEC_RST), .TVAL_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .exc_addr(exc_addr), .exc_ill(exc_ill), .exc_ecall(exc_ecall),
    .irq_timer(irq_timer), .mtie(mtie), .mret(mret), .freeze(freeze), .pc_id_ex(pc_id_ex),
    .badaddr_val(badaddr_val), .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc),
    .core_wr_en(core_wr_en), .core_adr(core_adr), .core_data(core_data),
    .csr_wr_en(csr_wr_en), .csr_adr_wr(csr_adr_wr), .csr_wrdata(csr_wrdata),
    .core_wr_ack(core_wr_ack), .trap_busy(trap_busy), .flush(flush),
    .pc_redirect_en(pc_redirect_en), .pc_redirect(pc_redirect), .trap_en(trap_en));
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic act_t mk(logic wr, logic [11:0] adr, logic [31:0] data, logic fl, logic rd, logic ret);
    act_t a;
    a.wr = wr; a.adr = adr; a.data = data; a.fl = fl; a.rd = rd; a.ret = ret;
    return a;
  endfunction
  // Compare at the falling edge, then advance the model for the coming rising edge.
  task automatic step();
    act_t a;
    logic [31:0] cause;
    @(negedge clk);
    if (!rst) q.delete();
    if (q.size() == 0) begin
      chk("wr_en", csr_wr_en, core_wr_en);
      chk("ack", core_wr_ack, core_wr_en);
      if (core_wr_en) begin
        chk("pass_adr", csr_adr_wr, core_adr);
        chk("pass_data", csr_wrdata, core_data);
      end
      chk("busy", trap_busy, 0);
      chk("flush", flush, 0);
      chk("trap_en", trap_en, 0);
      chk("redir_en", pc_redirect_en, 0);
      if (!rst) chk("rst_pc", pc_redirect, MTVEC_RST);
    end else begin
      a = q[0];
      chk("busy", trap_busy, 1);
      chk("ack", core_wr_ack, 0);
      chk("wr_en", csr_wr_en, a.wr & !freeze);
      chk("flush", flush, a.fl & !freeze);
      chk("trap_en", trap_en, a.fl & !freeze);
      chk("redir_en", pc_redirect_en, a.rd & !freeze);
      if (a.wr && !freeze) begin
        chk("csr_adr", csr_adr_wr, a.adr);
        chk("csr_data", csr_wrdata, a.data);
      end
      if (a.rd && !freeze) chk("redir_pc", pc_redirect, a.ret ? csr_mepc : {csr_mtvec[31:2], 2'b00});
    end
    if (rst) begin
      if (q.size() != 0) begin
        if (!freeze) void'(q.pop_front());
      end else if (!freeze) begin
        if (exc_addr | exc_ill | exc_ecall | (irq_timer & mtie)) begin
          cause = exc_addr ? 32'h0 : exc_ill ? 32'h2 : exc_ecall ? 32'hB : 32'h8000_0007;
          q.push_back(mk(1, 12'h341, pc_id_ex, 1, 0, 0));
          q.push_back(mk(1, 12'h342, cause, 0, 0, 0));
          if (cause == 0) q.push_back(mk(1, 12'h343, badaddr_val, 0, 0, 0));
          q.push_back(mk(0, 0, 0, 0, 1, 0));
        end else if (mret) q.push_back(mk(0, 0, 0, 0, 1, 1));
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic quiet();
    exc_addr = 0; exc_ill = 0; exc_ecall = 0; irq_timer = 0; mret = 0; freeze = 0;
  endtask
  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask
  initial begin
    rst = 0; quiet(); mtie = 0; core_wr_en = 0; core_adr = 12'h300; core_data = 32'h1234_5678;
    pc_id_ex = 0; badaddr_val = 0; csr_mtvec = 32'h203; csr_mepc = 32'h40;
    #2;
    steps(2);
    rst = 1; core_wr_en = 1; step();
    core_wr_en = 0;
    pc_id_ex = 32'h100; exc_ill = 1; step();
    quiet(); steps(4);
    exc_addr = 1; exc_ecall = 1; badaddr_val = 32'h1002; step();
    quiet(); steps(5);
    irq_timer = 1; mtie = 0; steps(2);
    mtie = 1; step();
    quiet(); steps(4);
    exc_ecall = 1; core_wr_en = 1; core_adr = 12'h305; step();
    quiet(); steps(4);
    core_wr_en = 0;
    mret = 1; step();
    quiet(); steps(2);
    mret = 1; exc_ecall = 1; step();
    quiet(); steps(4);
    freeze = 1; exc_ill = 1; core_wr_en = 1; step();
    freeze = 0; exc_ill = 0; core_wr_en = 0; step();
    exc_ill = 1; step();
    exc_ill = 0; step();
    freeze = 1; steps(3);
    freeze = 0; steps(3);
    exc_ill = 1; step();
    exc_ill = 0; rst = 0; step();
    rst = 1; steps(3);
    for (int i = 0; i < 3000; i++) begin
      rst         = $urandom_range(199) != 0;
      exc_addr    = $urandom_range(15) == 0;
      exc_ill     = $urandom_range(15) == 0;
      exc_ecall   = $urandom_range(15) == 0;
      irq_timer   = $urandom_range(7) == 0;
      mtie        = $urandom_range(1) == 0;
      mret        = $urandom_range(7) == 0;
      freeze      = $urandom_range(4) == 0;
      core_wr_en  = $urandom_range(1) == 0;
      core_adr    = 12'($urandom);
      core_data   = $urandom;
      pc_id_ex    = $urandom;
      badaddr_val = $urandom;
      csr_mtvec   = $urandom;
      csr_mepc    = $urandom;
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have parameters: MTVEC_RST 32'h0000_0000, reset value of the redirect-target register; TVAL_EN 1, when 1 mbadaddr is written for address-misaligned traps.
REQ-002 SHALL have ports (name, direction, width, meaning):
  clk  in  1  single clock, rising edge
  rst  in  1  asynchronous, active-low reset
  exc_addr  in  1  address-misaligned exception
  exc_ill  in  1  illegal-instruction exception
  exc_ecall  in  1  ecall
  irq_timer  in  1  timer interrupt request
  mtie  in  1  interrupt enable from CSR file
  mret  in  1  mret retiring
  freeze  in  1  pipeline freeze; sequencer holds
  pc_id_ex  in  32  PC of faulting instruction
  badaddr_val  in  32  faulting address
  csr_mtvec  in  32  trap vector
  csr_mepc  in  32  return address
  core_wr_en  in  1  core CSR-instruction write request
  core_adr  in  12  core write address
  core_data  in  32  core write data
  csr_wr_en  out  1  shared CSR write port enable
  csr_adr_wr  out  12  shared CSR write port address
  csr_wrdata  out  32  shared CSR write port data
  core_wr_ack  out  1  core write accepted this cycle
  trap_busy  out  1  stall pipeline
  flush  out  1  one-cycle pipeline flush
  pc_redirect_en  out  1  one-cycle PC redirect
  pc_redirect  out  32  redirect target
  trap_en  out  1  one-cycle trap-entry marker to CSR file

Function
REQ-003 SHALL implement states IDLE, SAVE_EPC, SAVE_CAUSE, SAVE_TVAL, REDIRECT, RET.
REQ-004 In IDLE the core write SHALL pass through combinationally: csr_wr_en=core_wr_en, csr_adr_wr=core_adr, csr_wrdata=core_data, core_wr_ack=core_wr_en.
REQ-005 Outside IDLE, core_wr_ack SHALL be 0 and the core write SHALL be blocked; the core holds its request.
REQ-006 Trap request SHALL be exc_addr | exc_ill | exc_ecall | (irq_timer & mtie), sampled in IDLE only.
REQ-007 Priority, highest first, with mcause: exc_addr 32'h0, exc_ill 32'h2, exc_ecall 32'hB, timer 32'h8000_0007.
REQ-008 When a trap is sampled in IDLE at cycle N, the block SHALL latch cause, pc_id_ex and badaddr_val, and enter SAVE_EPC at N+1.
REQ-009 A core write in cycle N SHALL still pass through, because it belongs to an older instruction.
REQ-010 SAVE_EPC SHALL write 12'h341 with the latched PC and pulse flush and trap_en.
REQ-011 SAVE_CAUSE SHALL write 12'h342 with the latched cause.
REQ-012 SAVE_TVAL SHALL write 12'h343 with the latched badaddr_val; it is entered only if cause=0 and TVAL_EN=1, otherwise SAVE_CAUSE goes directly to REDIRECT.
REQ-013 REDIRECT SHALL pulse pc_redirect_en with pc_redirect = {csr_mtvec[31:2],2'b00}, then return to IDLE; no CSR write occurs.
REQ-014 mret in IDLE with no trap request SHALL enter RET; RET pulses pc_redirect_en with pc_redirect=csr_mepc and returns to IDLE.
REQ-015 A trap and mret in the same cycle: the trap wins and mret is dropped.
REQ-016 trap_busy SHALL be 1 in every state except IDLE.
REQ-017 Trap and mret inputs arriving outside IDLE SHALL be ignored.
REQ-018 While freeze=1 in a non-IDLE state, the state SHALL hold and csr_wr_en, flush, trap_en and pc_redirect_en SHALL be 0; the action executes once freeze drops.
REQ-019 In IDLE, freeze SHALL block trap/mret sampling but not the core write pass-through.
REQ-020 All outputs other than the IDLE pass-through SHALL be decoded from registered state and latched values.

Reset
REQ-021 On rst=0, state SHALL be IDLE, latches 0, and outputs 0 except pass-through terms; pc_redirect SHALL be MTVEC_RST.
REQ-022 Reset mid-sequence SHALL abort immediately with no further CSR writes.
REQ-023 The first trap SHALL be sampled at the first rising edge after rst is released.

Verification
REQ-024 exc_ill at N, pc_id_ex=32'h100, csr_mtvec=32'h203 -> N+1 write 341/100 with flush; N+2 write 342/2; N+3 redirect to 32'h200; IDLE at N+4.
REQ-025 exc_addr with exc_ecall, badaddr_val=32'h1002 -> mcause 0, SAVE_TVAL writes 343/1002, redirect at N+4.
REQ-026 irq_timer=1 with mtie=0 -> no activity; with mtie=1 -> mcause 32'h8000_0007 written.
REQ-027 core_wr_en held from N+1 to N+3 during a trap -> ack 0 in those cycles, ack 1 on return to IDLE.
REQ-028 mret with csr_mepc=32'h40 -> RET redirect to 32'h40; mret together with exc_ecall -> trap sequence only.
REQ-029 freeze=1 for 3 cycles in SAVE_CAUSE -> write delayed 3 cycles, issued once; rst=0 in SAVE_EPC -> IDLE, no further writes.
